hybrid_ctrl_fsm: RTL and testbench

- Multicycle main controller for the hybrid ARM/MIPS core.
- Sequences fetch, decode, execute, memory and writeback for one instruction at a time.
- Drives the datapath enables and the immediate-extension selects ImmSrc/ImmExt, which choose the 14/27-bit field and sign/zero extension.
- Waits on a memory ready handshake; counts retired instructions.

---
 rtl/hybrid_ctrl_fsm_if.sv | 38 +++
 rtl/hybrid_ctrl_fsm.sv | 162 ++++++++++++++++
 tb/tb_hybrid_ctrl_fsm.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/hybrid_ctrl_fsm_if.sv
// Control bus between the multicycle main controller and the datapath/memory side.
// The controller drives it through the master modport; the datapath side uses slave.
interface hybrid_ctrl_fsm_if #(
  parameter int CNT_W   = 32,
  parameter int ALUOP_W = 4
);
  logic [4:0]         Op;
  logic               Zero;
  logic               mem_ready;
  logic               IRWrite;
  logic               PCWrite;
  logic [1:0]         PCSrc;
  logic               MemRead;
  logic               MemWrite;
  logic               RegWrite;
  logic               MemtoReg;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [ALUOP_W-1:0] ALUOp;
  logic               ImmSrc;
  logic               ImmExt;
  logic               Illegal;
  logic               Halted;
  logic [CNT_W-1:0]   Retired;
  logic [3:0]         State;

  modport master (
    input  Op, Zero, mem_ready,
    output IRWrite, PCWrite, PCSrc, MemRead, MemWrite, RegWrite, MemtoReg,
           ALUSrcA, ALUSrcB, ALUOp, ImmSrc, ImmExt, Illegal, Halted, Retired, State
  );

  modport slave (
    output Op, Zero, mem_ready,
    input  IRWrite, PCWrite, PCSrc, MemRead, MemWrite, RegWrite, MemtoReg,
           ALUSrcA, ALUSrcB, ALUOp, ImmSrc, ImmExt, Illegal, Halted, Retired, State
  );
endinterface

// File: rtl/hybrid_ctrl_fsm.sv
// Multicycle main controller for the hybrid ARM/MIPS core: fetch/decode/execute/
// memory/writeback sequencing, immediate-format selects and a retired counter.
module hybrid_ctrl_fsm #(
  parameter int CNT_W   = 32,
  parameter int ALUOP_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  hybrid_ctrl_fsm_if.master ctl
);
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    ALU_WB   = 4'd4,
    MEM_ADDR = 4'd5,
    MEM_RD   = 4'd6,
    MEM_WB   = 4'd7,
    MEM_WR   = 4'd8,
    BRANCH   = 4'd9,
    JUMP     = 4'd10,
    HALT     = 4'd11
  } state_e;

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);

  state_e           state_q, state_d;
  logic             imm_src_q, imm_ext_q;
  logic [CNT_W-1:0] retired_q;
  logic             retire;

  logic op_r, op_i, op_ld, op_st, op_br, op_jmp, op_b, op_halt;
  logic imm_src_dec, imm_ext_dec;

  always_comb begin
    op_r    = (ctl.Op[4:3] == 2'b00);
    op_i    = (ctl.Op[4:3] == 2'b01);
    op_ld   = (ctl.Op == 5'b10000);
    op_st   = (ctl.Op == 5'b10001);
    op_br   = (ctl.Op[4:1] == 4'b1001);
    op_jmp  = (ctl.Op == 5'b10100);
    op_b    = (ctl.Op == 5'b10101);
    op_halt = (ctl.Op == 5'b11111);
    // imm27 only for jumps; add/sub I-types, memory, branches and B sign-extend
    imm_src_dec = op_jmp | op_b;
    imm_ext_dec = (op_i & ~ctl.Op[2]) | op_ld | op_st | op_br | op_b;
  end

  always_comb begin
    state_d      = state_q;
    ctl.IRWrite  = 1'b0;
    ctl.PCWrite  = 1'b0;
    ctl.PCSrc    = 2'd0;
    ctl.MemRead  = 1'b0;
    ctl.MemWrite = 1'b0;
    ctl.RegWrite = 1'b0;
    ctl.MemtoReg = 1'b0;
    ctl.ALUSrcA  = 1'b0;
    ctl.ALUSrcB  = 2'd0;
    ctl.ALUOp    = ALU_ADD;
    ctl.Illegal  = 1'b0;
    case (state_q)
      FETCH: begin
        ctl.MemRead = 1'b1;
        ctl.ALUSrcB = 2'd1;
        ctl.IRWrite = ctl.mem_ready;
        ctl.PCWrite = ctl.mem_ready;
        if (ctl.mem_ready) state_d = DECODE;
      end
      DECODE: begin
        ctl.ALUSrcB = 2'd2;
        if (op_r)                    state_d = EXEC_R;
        else if (op_i)               state_d = EXEC_I;
        else if (op_ld | op_st)      state_d = MEM_ADDR;
        else if (op_br)              state_d = BRANCH;
        else if (op_jmp | op_b)      state_d = JUMP;
        else if (op_halt)            state_d = HALT;
        else begin
          ctl.Illegal = 1'b1;
          state_d     = FETCH;
        end
      end
      EXEC_R: begin
        ctl.ALUSrcA = 1'b1;
        ctl.ALUOp   = {1'b0, ctl.Op[2:0]};
        state_d     = ALU_WB;
      end
      EXEC_I: begin
        ctl.ALUSrcA = 1'b1;
        ctl.ALUSrcB = 2'd2;
        ctl.ALUOp   = {1'b0, ctl.Op[2:0]};
        state_d     = ALU_WB;
      end
      ALU_WB: begin
        ctl.RegWrite = 1'b1;
        state_d      = FETCH;
      end
      MEM_ADDR: begin
        ctl.ALUSrcA = 1'b1;
        ctl.ALUSrcB = 2'd2;
        state_d     = op_st ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        ctl.MemRead = 1'b1;
        if (ctl.mem_ready) state_d = MEM_WB;
      end
      MEM_WB: begin
        ctl.RegWrite = 1'b1;
        ctl.MemtoReg = 1'b1;
        state_d      = FETCH;
      end
      MEM_WR: begin
        ctl.MemWrite = 1'b1;
        if (ctl.mem_ready) state_d = FETCH;
      end
      BRANCH: begin
        ctl.ALUSrcA = 1'b1;
        ctl.ALUOp   = ALU_SUB;
        ctl.PCSrc   = 2'd1;
        // Op[0] distinguishes BNE from BEQ
        ctl.PCWrite = ctl.Zero ^ ctl.Op[0];
        state_d     = FETCH;
      end
      JUMP: begin
        ctl.PCWrite = 1'b1;
        ctl.PCSrc   = 2'd2;
        state_d     = FETCH;
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase

    // An illegal opcode also returns to FETCH from DECODE, so it is never counted
    retire = ((state_d == FETCH) &&
              (state_q inside {ALU_WB, MEM_WB, MEM_WR, BRANCH, JUMP})) ||
             ((state_q == DECODE) && (state_d == HALT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      imm_src_q <= 1'b0;
      imm_ext_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) begin
        imm_src_q <= imm_src_dec;
        imm_ext_q <= imm_ext_dec;
      end
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign ctl.ImmSrc  = imm_src_q;
  assign ctl.ImmExt  = imm_ext_q;
  assign ctl.Halted  = (state_q == HALT);
  assign ctl.Retired = retired_q;
  assign ctl.State   = state_q;
endmodule

// File: tb/tb_hybrid_ctrl_fsm.sv
// Directed bench for hybrid_ctrl_fsm: a per-cycle vector table for the normal
// instruction flows plus hand sequences for illegal, reset-in-wait and halt.
module tb_hybrid_ctrl_fsm;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  hybrid_ctrl_fsm_if #(.CNT_W(32), .ALUOP_W(4)) bus ();
  hybrid_ctrl_fsm #(.CNT_W(32), .ALUOP_W(4)) dut (.clk(clk), .rst_n(rst_n), .ctl(bus));

  typedef struct {
    logic [4:0] op; logic z; logic r;
    logic [3:0] st; logic irw; logic pcw; logic [1:0] ps;
    logic mrd; logic mwr; logic rw; logic m2r; logic asa; logic [1:0] asb;
    logic [3:0] alu; logic isrc; logic iext; logic ill; logic hlt; int ret;
  } vec_t;

  vec_t tbl[$];

  function automatic void v(logic [4:0] op, logic z, logic r, logic [3:0] st,
                            logic irw, logic pcw, logic [1:0] ps, logic mrd, logic mwr,
                            logic rw, logic m2r, logic asa, logic [1:0] asb,
                            logic [3:0] alu, logic isrc, logic iext, logic ill,
                            logic hlt, int ret);
    vec_t e;
    e.op = op; e.z = z; e.r = r; e.st = st; e.irw = irw; e.pcw = pcw; e.ps = ps;
    e.mrd = mrd; e.mwr = mwr; e.rw = rw; e.m2r = m2r; e.asa = asa; e.asb = asb;
    e.alu = alu; e.isrc = isrc; e.iext = iext; e.ill = ill; e.hlt = hlt; e.ret = ret;
    tbl.push_back(e);
  endfunction

  function automatic logic [22:0] outs();
    return {bus.State, bus.IRWrite, bus.PCWrite, bus.PCSrc, bus.MemRead, bus.MemWrite,
            bus.RegWrite, bus.MemtoReg, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
            bus.ImmSrc, bus.ImmExt, bus.Illegal, bus.Halted};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic [4:0] op, input logic z, input logic r);
    @(negedge clk);
    bus.Op = op; bus.Zero = z; bus.mem_ready = r;
    #1;
  endtask

  initial begin
    logic [22:0] exp;
    bus.Op = 5'd0; bus.Zero = 1'b0; bus.mem_ready = 1'b0;

    //  op     z r st irw pcw ps mrd mwr rw m2r asa asb alu isrc iext ill hlt ret
    // R-type add/sub class
    v(5'h02, 0,1, 0, 1,1,0, 1,0,0,0, 0,1, 0, 0,0,0,0, 0);
    v(5'h02, 0,1, 1, 0,0,0, 0,0,0,0, 0,2, 0, 0,0,0,0, 0);
    v(5'h02, 0,1, 2, 0,0,0, 0,0,0,0, 1,0, 2, 0,0,0,0, 0);
    v(5'h02, 0,1, 4, 0,0,0, 0,0,1,0, 0,0, 0, 0,0,0,0, 0);
    // I-type logic: zero-extend imm14
    v(5'h0C, 0,1, 0, 1,1,0, 1,0,0,0, 0,1, 0, 0,0,0,0, 1);
    v(5'h0C, 0,1, 1, 0,0,0, 0,0,0,0, 0,2, 0, 0,0,0,0, 1);
    v(5'h0C, 0,1, 3, 0,0,0, 0,0,0,0, 1,2, 4, 0,0,0,0, 1);
    v(5'h0C, 0,1, 4, 0,0,0, 0,0,1,0, 0,0, 0, 0,0,0,0, 1);
    // I-type add: sign-extend imm14
    v(5'h08, 0,1, 0, 1,1,0, 1,0,0,0, 0,1, 0, 0,0,0,0, 2);
    v(5'h08, 0,1, 1, 0,0,0, 0,0,0,0, 0,2, 0, 0,0,0,0, 2);
    v(5'h08, 0,1, 3, 0,0,0, 0,0,0,0, 1,2, 0, 0,1,0,0, 2);
    v(5'h08, 0,1, 4, 0,0,0, 0,0,1,0, 0,0, 0, 0,1,0,0, 2);
    // LOAD: one FETCH wait, then MEM_RD held 3 cycles
    v(5'h10, 0,0, 0, 0,0,0, 1,0,0,0, 0,1, 0, 0,1,0,0, 3);
    v(5'h10, 0,1, 0, 1,1,0, 1,0,0,0, 0,1, 0, 0,1,0,0, 3);
    v(5'h10, 0,1, 1, 0,0,0, 0,0,0,0, 0,2, 0, 0,1,0,0, 3);
    v(5'h10, 0,1, 5, 0,0,0, 0,0,0,0, 1,2, 0, 0,1,0,0, 3);
    v(5'h10, 0,0, 6, 0,0,0, 1,0,0,0, 0,0, 0, 0,1,0,0, 3);
    v(5'h10, 0,0, 6, 0,0,0, 1,0,0,0, 0,0, 0, 0,1,0,0, 3);
    v(5'h10, 0,0, 6, 0,0,0, 1,0,0,0, 0,0, 0, 0,1,0,0, 3);
    v(5'h10, 0,1, 6, 0,0,0, 1,0,0,0, 0,0, 0, 0,1,0,0, 3);
    v(5'h10, 0,0, 7, 0,0,0, 0,0,1,1, 0,0, 0, 0,1,0,0, 3);
    // BEQ taken
    v(5'h12, 1,1, 0, 1,1,0, 1,0,0,0, 0,1, 0, 0,1,0,0, 4);
    v(5'h12, 1,1, 1, 0,0,0, 0,0,0,0, 0,2, 0, 0,1,0,0, 4);
    v(5'h12, 1,1, 9, 0,1,1, 0,0,0,0, 1,0, 1, 0,1,0,0, 4);
    // BNE with Zero=1: not taken
    v(5'h13, 1,1, 0, 1,1,0, 1,0,0,0, 0,1, 0, 0,1,0,0, 5);
    v(5'h13, 1,1, 1, 0,0,0, 0,0,0,0, 0,2, 0, 0,1,0,0, 5);
    v(5'h13, 1,1, 9, 0,0,1, 0,0,0,0, 1,0, 1, 0,1,0,0, 5);
    // BNE with Zero=0: taken
    v(5'h13, 0,1, 0, 1,1,0, 1,0,0,0, 0,1, 0, 0,1,0,0, 6);
    v(5'h13, 0,1, 1, 0,0,0, 0,0,0,0, 0,2, 0, 0,1,0,0, 6);
    v(5'h13, 0,1, 9, 0,1,1, 0,0,0,0, 1,0, 1, 0,1,0,0, 6);
    // JMP: imm27 zero-extended
    v(5'h14, 0,1, 0, 1,1,0, 1,0,0,0, 0,1, 0, 0,1,0,0, 7);
    v(5'h14, 0,1, 1, 0,0,0, 0,0,0,0, 0,2, 0, 0,1,0,0, 7);
    v(5'h14, 0,1,10, 0,1,2, 0,0,0,0, 0,0, 0, 1,0,0,0, 7);
    // B: imm27 sign-extended
    v(5'h15, 0,1, 0, 1,1,0, 1,0,0,0, 0,1, 0, 1,0,0,0, 8);
    v(5'h15, 0,1, 1, 0,0,0, 0,0,0,0, 0,2, 0, 1,0,0,0, 8);
    v(5'h15, 0,1,10, 0,1,2, 0,0,0,0, 0,0, 0, 1,1,0,0, 8);
    v(5'h15, 0,0, 0, 0,0,0, 1,0,0,0, 0,1, 0, 1,1,0,0, 9);

    // reset state, sampled while reset is held
    @(negedge clk);
    chk("reset_state", 32'(bus.State), 32'd0);
    chk("reset_retired", bus.Retired, 32'd0);
    chk("reset_flags", {28'd0, bus.ImmSrc, bus.ImmExt, bus.Illegal, bus.Halted}, 32'd0);
    chk("reset_fetch_mrd_asb", {29'd0, bus.MemRead, bus.ALUSrcB}, {29'd0, 1'b1, 2'd1});
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].op, tbl[i].z, tbl[i].r);
      exp = {tbl[i].st, tbl[i].irw, tbl[i].pcw, tbl[i].ps, tbl[i].mrd, tbl[i].mwr,
             tbl[i].rw, tbl[i].m2r, tbl[i].asa, tbl[i].asb, tbl[i].alu,
             tbl[i].isrc, tbl[i].iext, tbl[i].ill, tbl[i].hlt};
      chk($sformatf("row%0d_ctl", i), 32'(outs()), 32'(exp));
      chk($sformatf("row%0d_retired", i), bus.Retired, tbl[i].ret);
    end

    // illegal opcode: one-cycle pulse, back to FETCH, not counted
    step(5'h18, 0, 1);
    chk("ill_fetch", 32'(bus.State), 32'd0);
    step(5'h18, 0, 1);
    chk("ill_decode_state", 32'(bus.State), 32'd1);
    chk("ill_pulse", 32'(bus.Illegal), 32'd1);
    step(5'h18, 0, 0);
    chk("ill_back_state", 32'(bus.State), 32'd0);
    chk("ill_pulse_gone", 32'(bus.Illegal), 32'd0);
    chk("ill_retired", bus.Retired, 32'd9);

    // reset asserted mid-wait in MEM_WR
    step(5'h11, 0, 1);
    step(5'h11, 0, 1);
    step(5'h11, 0, 1);
    chk("st_addr", 32'(bus.State), 32'd5);
    step(5'h11, 0, 0);
    step(5'h11, 0, 0);
    chk("st_wait_state", 32'(bus.State), 32'd8);
    chk("st_wait_mwr", 32'(bus.MemWrite), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_state", 32'(bus.State), 32'd0);
    chk("rst_async_mwr", 32'(bus.MemWrite), 32'd0);
    chk("rst_async_mrd", 32'(bus.MemRead), 32'd1);
    chk("rst_async_asb", 32'(bus.ALUSrcB), 32'd1);
    chk("rst_async_retired", bus.Retired, 32'd0);
    chk("rst_async_imm", {30'd0, bus.ImmSrc, bus.ImmExt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // STORE completing normally
    step(5'h11, 0, 1);
    step(5'h11, 0, 1);
    step(5'h11, 0, 1);
    step(5'h11, 0, 0);
    chk("st2_wait", 32'(bus.State), 32'd8);
    step(5'h11, 0, 1);
    chk("st2_done_mwr", 32'(bus.MemWrite), 32'd1);
    step(5'h1F, 0, 1);
    chk("st2_fetch", 32'(bus.State), 32'd0);
    chk("st2_retired", bus.Retired, 32'd1);

    // HALT: counted once, then stuck regardless of inputs
    step(5'h1F, 0, 1);
    chk("halt_decode", 32'(bus.State), 32'd1);
    for (int k = 0; k < 5; k++) begin
      step(5'(k * 7), k[0], ~k[0]);
      chk($sformatf("halt_hold%0d", k),
          {bus.State, bus.Halted, bus.MemRead, bus.PCWrite, bus.IRWrite},
          {4'd11, 1'b1, 3'd0});
      chk($sformatf("halt_retired%0d", k), bus.Retired, 32'd2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
